// File: rtl/mod_sub_arb_pkg.sv
// Shared defaults and types for the round-robin modular-subtraction arbiter.
package mod_sub_arb_pkg;

    localparam int unsigned W_DEF    = 48;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned IDW_DEF  = $clog2(NREQ_DEF);

    typedef logic [W_DEF-1:0]   word_t;
    typedef logic [IDW_DEF-1:0] req_id_t;

    // Pointer starts at the last index so the first grant after reset goes to requester 0.
    localparam req_id_t RR_LAST_RST = req_id_t'(NREQ_DEF - 1);

    function automatic int unsigned rr_last_rst(input int unsigned nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/mod_sub_rr_arb_rr_grant.sv
// Combinational round-robin grant: searches from last+1 with wrap-around and returns
// a one-hot grant plus its encoded index.
module rr_grant
    import mod_sub_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_any_o
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = IDW'(idx);
            end
        end
        gnt_any_o = found;
    end

endmodule

// File: rtl/mod_sub_rr_arb.sv
// Round-robin arbiter feeding a 2-stage pipelined B = (A - M) mod q datapath.
// Define MOD_SUB_ARB_STALL_EN to add the rsp_ready port and consumer backpressure.
module mod_sub_rr_arb
    import mod_sub_arb_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_m,
    input  logic [NREQ*W-1:0] req_q,
`ifdef MOD_SUB_ARB_STALL_EN
    input  logic              rsp_ready,
`endif
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_b,
    output logic [IDW-1:0]    rsp_id
);

    localparam logic [IDW-1:0] LastRst = IDW'(rr_last_rst(NREQ));

    logic            stall;
    logic            accept;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;

    logic [IDW-1:0]  last_q, last_d;

    logic            s1_vld_q, s1_vld_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_m_q, s1_m_d;
    logic [W-1:0]    s1_mod_q, s1_mod_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_b_q, rsp_b_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic [W-1:0]    a_sel, m_sel, q_sel;
    logic [W:0]      diff;
    logic [W-1:0]    corr;
    logic [W-1:0]    b_calc;

`ifdef MOD_SUB_ARB_STALL_EN
    assign stall = rsp_valid_q && !rsp_ready;
`else
    assign stall = 1'b0;
`endif

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (gnt_any)
    );

    // Grants are suppressed during reset as well as during a stall.
    assign req_ready = (stall || rst) ? '0 : gnt;
    assign accept    = gnt_any && !stall && !rst;

    always_comb begin
        a_sel = '0;
        m_sel = '0;
        q_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*W +: W];
                m_sel = req_m[i*W +: W];
                q_sel = req_q[i*W +: W];
            end
        end
    end

    always_comb begin
        last_d   = last_q;
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_m_d   = s1_m_q;
        s1_mod_d = s1_mod_q;
        s1_id_d  = s1_id_q;
        if (!stall) begin
            s1_vld_d = accept;
            if (accept) begin
                last_d   = gnt_id;
                s1_a_d   = a_sel;
                s1_m_d   = m_sel;
                s1_mod_d = q_sel;
                s1_id_d  = gnt_id;
            end
        end
    end

    // diff[W] is the borrow, set exactly when m > a.
    always_comb begin
        diff   = {1'b0, s1_a_q} - {1'b0, s1_m_q};
        corr   = diff[W-1:0] + s1_mod_q;
        b_calc = diff[W] ? corr : diff[W-1:0];
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_b_d     = rsp_b_q;
        rsp_id_d    = rsp_id_q;
        if (!stall) begin
            rsp_valid_d = s1_vld_q;
            if (s1_vld_q) begin
                rsp_b_d  = b_calc;
                rsp_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= LastRst;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_m_q      <= '0;
            s1_mod_q    <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_b_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            last_q      <= last_d;
            s1_vld_q    <= s1_vld_d;
            s1_a_q      <= s1_a_d;
            s1_m_q      <= s1_m_d;
            s1_mod_q    <= s1_mod_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_b_q     <= rsp_b_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mod_sub_rr_arb.sv
// Self-checking bench for mod_sub_rr_arb: directed scenarios plus random traffic against
// a scoreboard model; stall scenarios run only when MOD_SUB_ARB_STALL_EN is defined.
module tb_mod_sub_rr_arb;
    import mod_sub_arb_pkg::*;

    localparam int unsigned W    = W_DEF;
    localparam int unsigned NREQ = NREQ_DEF;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam logic [W-1:0] MAXW = {W{1'b1}};

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] b;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_m, req_q;
    logic              rdy;
    logic              rsp_valid;
    logic [W-1:0]      rsp_b;
    logic [IDW-1:0]    rsp_id;

    logic [NREQ-1:0]   vld;
    word_t             ra [NREQ];
    word_t             rm [NREQ];
    word_t             rq [NREQ];
    logic [NREQ-1:0]   taken;
    int                mode;

    exp_t              sb [$];
    int                log_q [$];
    int                cyc;
    int                last_m;
    int                n_acc;
    int                n_chk;
    int                n_pass;

    logic              smp_valid;
    logic [W-1:0]      smp_b;
    logic [IDW-1:0]    smp_id;
    logic [W-1:0]      held_b;
    logic [IDW-1:0]    held_id;

    always #5 clk = ~clk;

    assign req_valid = vld;
    always_comb begin
        req_a = '0;
        req_m = '0;
        req_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = ra[i];
            req_m[i*W +: W] = rm[i];
            req_q[i*W +: W] = rq[i];
        end
    end

    mod_sub_rr_arb #(
        .W    (W),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_m     (req_m),
        .req_q     (req_q),
`ifdef MOD_SUB_ARB_STALL_EN
        .rsp_ready (rdy),
`endif
        .rsp_valid (rsp_valid),
        .rsp_b     (rsp_b),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Modular subtraction from the arithmetic definition, truncated to W bits.
    function automatic logic [W-1:0] ref_sub(input logic [63:0] a, input logic [63:0] m,
                                             input logic [63:0] q);
        logic [63:0] r;
        if (m > a) r = a + q - m;
        else r = a - m;
        return r[W-1:0];
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic word_t rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic new_data(input int i);
        rq[i] = rnd_word() | word_t'(1);
        if ($urandom_range(0, 1) == 1) begin
            ra[i] = rnd_word() % rq[i];
            rm[i] = rnd_word() % rq[i];
        end else begin
            ra[i] = rnd_word();
            rm[i] = rnd_word();
        end
    endtask

    // One clock: check at the falling edge, update requesters just after the rising edge.
    task automatic step();
        int              win;
        bit              exp_v;
        bit              stall_m;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        @(negedge clk);
        cyc++;
        exp_v   = (sb.size() > 0) && (sb[0].due == cyc);
        stall_m = exp_v && !rdy;
        win     = pick(vld, last_m);
        exp_rdy = '0;
        if (win >= 0 && !stall_m) exp_rdy[win] = 1'b1;
        smp_valid = rsp_valid;
        smp_b     = rsp_b;
        smp_id    = rsp_id;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            chk("rsp_b", 64'(rsp_b), 64'(sb[0].b));
            chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        end
        if (rsp_valid && rdy) log_q.push_back(int'(rsp_id));
        if (stall_m) begin
            for (int k = 0; k < sb.size(); k++) begin
                e = sb[k];
                e.due++;
                sb[k] = e;
            end
        end else if (exp_v) begin
            void'(sb.pop_front());
        end
        if (win >= 0 && !stall_m) begin
            e.due = cyc + 2;
            e.id  = win;
            e.b   = ref_sub(64'(ra[win]), 64'(rm[win]), 64'(rq[win]));
            sb.push_back(e);
            last_m     = win;
            taken[win] = 1'b1;
            n_acc++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (taken[i]) begin
                taken[i] = 1'b0;
                if (mode == 0) vld[i] = 1'b0;
                else if (mode == 1) new_data(i);
                else begin
                    vld[i] = 1'($urandom_range(0, 1));
                    new_data(i);
                end
            end else if (mode == 2 && !vld[i]) begin
                vld[i] = 1'($urandom_range(0, 1));
                new_data(i);
            end
        end
    endtask

    task automatic issue(input int i, input word_t a, input word_t m, input word_t q);
        ra[i]  = a;
        rm[i]  = m;
        rq[i]  = q;
        vld[i] = 1'b1;
        step();
    endtask

    task automatic drain();
        mode = 0;
        vld  = '0;
        rdy  = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        n_acc  = 0;
        last_m = NREQ - 1;
        taken  = '0;
        rdy    = 1'b1;
        mode   = 1;
        rst    = 1'b1;
        vld    = '1;
        for (int i = 0; i < NREQ; i++) new_data(i);

        // Reset state, with every requester already valid.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_b", 64'(rsp_b), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // Fairness from reset: all valid continuously.
        repeat (8) step();
        drain();
        chk("fair_count", 64'(log_q.size()), 64'd8);
        for (int k = 0; k < 6; k++) chk("fair_order", 64'(log_q[k]), 64'(k % NREQ));

        // Single requester, q = 97.
        issue(2, 48'd10, 48'd20, 48'd97);
        issue(2, 48'd50, 48'd20, 48'd97);
        issue(2, 48'd33, 48'd33, 48'd97);
        chk("q97_wrap_b", 64'(smp_b), 64'd87);
        chk("q97_wrap_id", 64'(smp_id), 64'd2);
        step();
        chk("q97_plain_b", 64'(smp_b), 64'd30);
        step();
        chk("q97_zero_b", 64'(smp_b), 64'd0);
        drain();

        // Width boundary operands.
        issue(0, 48'd0, MAXW, MAXW);
        issue(0, MAXW, 48'd0, MAXW);
        step();
        chk("wbound_zero", 64'(smp_b), 64'd0);
        step();
        chk("wbound_max", 64'(smp_b), 64'(MAXW));
        drain();

        // Sparse round-robin: set last=1, then 1 and 3 valid, 0 joins later.
        log_q.delete();
        issue(1, 48'd5, 48'd1, 48'd7);
        mode   = 1;
        vld[1] = 1'b1;
        vld[3] = 1'b1;
        new_data(1);
        new_data(3);
        repeat (3) step();
        vld[0] = 1'b1;
        new_data(0);
        repeat (2) step();
        drain();
        begin
            int exp_ids [6] = '{1, 3, 1, 3, 0, 1};
            chk("sparse_count", 64'(log_q.size()), 64'd6);
            for (int k = 0; k < 6; k++) chk("sparse_order", 64'(log_q[k]), 64'(exp_ids[k]));
        end

`ifdef MOD_SUB_ARB_STALL_EN
        // Consumer backpressure with results in flight.
        log_q.delete();
        n_acc = 0;
        mode  = 1;
        vld   = '1;
        for (int i = 0; i < NREQ; i++) new_data(i);
        repeat (3) step();
        rdy = 1'b0;
        step();
        held_b  = smp_b;
        held_id = smp_id;
        repeat (4) begin
            step();
            chk("stall_hold_b", 64'(smp_b), 64'(held_b));
            chk("stall_hold_id", 64'(smp_id), 64'(held_id));
        end
        rdy = 1'b1;
        repeat (3) step();
        drain();
        chk("stall_count", 64'(log_q.size()), 64'(n_acc));
        for (int k = 1; k < log_q.size(); k++)
            chk("stall_order", 64'(log_q[k]), 64'((log_q[k-1] + 1) % NREQ));
`endif

        // Reset with results in flight.
        mode = 1;
        vld  = '1;
        for (int i = 0; i < NREQ; i++) new_data(i);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        sb.delete();
        log_q.delete();
        last_m = NREQ - 1;
        n_acc  = 0;
        taken  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        drain();
        chk("midrst_first_id", 64'(log_q[0]), 64'd0);
        chk("midrst_count", 64'(log_q.size()), 64'(n_acc));

        // Random traffic with random consumer backpressure.
        mode = 2;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'($urandom_range(0, 1));
            new_data(i);
        end
        repeat (400) begin
`ifdef MOD_SUB_ARB_STALL_EN
            rdy = ($urandom_range(0, 3) != 0);
`endif
            step();
        end
        drain();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_sub_rr_arb.md
# mod_sub_rr_arb

Round-robin scheduler that time-shares one pipelined modular-subtraction datapath (B = (A − M) mod q) between NREQ independent requesters inside the NTT butterfly/post-processing path. Each requester offers an operand pair plus modulus through a valid/ready handshake. The block grants at most one request per cycle and pushes it through a 2-stage registered subtract/correct pipe. It returns the result tagged with the requester index, and can optionally apply backpressure from the consumer.

## Interface
- W, 48, operand/modulus/result width
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), requester-index width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*W  packed minuends, slice i belongs to requester i
- req_m  in  NREQ*W  packed subtrahends
- req_q  in  NREQ*W  packed moduli
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept (present only with MOD_SUB_ARB_STALL_EN)
- rsp_b  out  W  result
- rsp_id  out  IDW  index of requester that issued the result

## Operation
- Accept: a transfer on requester i occurs when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid, the RR pointer and stall. Requesters hold valid and data until accepted.
- Arbitration: search starts at index (last+1) mod NREQ and wraps. The first valid requester wins. last updates to the winner only on an accepted transfer. A single valid requester is granted every cycle.
- Stage 1 (issue reg): captures a, m, q, id and a valid bit. The valid bit is 0 when there is no grant.
- Stage 2 (result reg): d = a − m (W+1 bits). If m > a, b = (d + q)[W−1:0]; otherwise b = d[W−1:0]. rsp_b, rsp_id and rsp_valid are registered.
- Operands with a ≥ q or m ≥ q are not checked. The result is the formula above truncated to W bits.
- Stall (macro on): stall = rsp_valid && !rsp_ready. While stall is high, both stages hold, req_ready = 0 and the RR pointer holds. No result is dropped or duplicated.
- Bubbles: an empty stage 1 advances as a bubble. rsp_valid is low in the cycle a bubble reaches stage 2.

## Timing
- Latency: accept in cycle n → rsp_valid in cycle n+2 (no stall).
- Throughput: 1 result/cycle sustained when any requester is valid.
- Reset: asynchronous clear of all state.
  - Pipe valid bits = 0. rsp_valid = 0, rsp_b = 0, rsp_id = 0.
  - last = NREQ−1, so the first grant after reset goes to requester 0.
- Reset asserted mid-operation: in-flight results are discarded and never presented. req_ready is 0 while rst is high.
- rsp_ready toggling with rsp_valid low has no effect.
- Simultaneous accept and stall release in the same cycle is allowed. The new request enters stage 1 as stage 1 drains.

## Configuration
- MOD_SUB_ARB_STALL_EN defined:
  - rsp_ready port exists.
  - The pipe stalls as described under Stall.
  - The consumer may hold rsp_ready low indefinitely.
- MOD_SUB_ARB_STALL_EN undefined:
  - No rsp_ready port.
  - The pipe never stalls and results are presented for exactly one cycle.
  - req_ready depends only on req_valid and the RR pointer.

## Structure
- Package mod_sub_arb_pkg holds:
  - defaults for W and NREQ
  - typedef for the operand word (logic [W−1:0])
  - typedef for the requester index
  - the reset value of the RR pointer
- Sub-module rr_grant: combinational round-robin grant from a request vector and last pointer, outputting a one-hot grant and an encoded index. The pointer register lives in mod_sub_rr_arb.

## Test plan
- Single request, q=97: requester 2, a=10, m=20 → cycle+2: rsp_b=87, rsp_id=2. Then a=50, m=20 → rsp_b=30. Then a=m=33 → rsp_b=0.
- Fairness: all 4 valid continuously from reset → accept order 0,1,2,3,0,1. Results are back-to-back with matching ids.
- Sparse round-robin: requesters 1 and 3 valid, last=1 → grant 3, then 1, then 3. Requester 0 asserting mid-stream → granted after 3, before 1.
- W boundary: a=0, m=2^48−1, q=2^48−1 → rsp_b=0. a=2^48−1, m=0 → rsp_b=2^48−1.
- Stall (macro on): hold rsp_ready=0 for 5 cycles with results in flight.
  - rsp_b and rsp_id stay stable and req_ready=0.
  - On release, the remaining results arrive in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 results in flight.
  - rsp_valid=0 immediately.
  - After release, the first grant goes to requester 0 and no stale results appear.
